spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
SPI mode-0 initiator that drives the same command protocol the FPGA SPI command slave decodes: a command byte, its parameter bytes, and dummy bytes for read-back.
- Used for FPGA-side self-test and bench loopback against the command slave.
- Also used as the host-side engine when one board drives another board's CS_FPGA/SCK/MOSI/MISO.
- Frames a byte stream under one CS assertion, shifts MSB-first, and returns one received byte per transmitted byte.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period (legal range 2..255).
CS_SETUP, 2, clk cycles from CS_N falling to the start of the first SCK low phase.
CS_GAP, 4, minimum clk cycles CS_N stays high after a frame before the next frame may start.

Ports:
clk  in  1  system clock (84 MHz PLL output)
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a frame; sampled only in IDLE
len  in  3  bytes in the frame, 1..6 (command plus up to 5 params/dummies)
tx_data  in  8  next byte to send
tx_valid  in  1  tx_data is valid
tx_ready  out  1  byte accepted this cycle (tx_valid && tx_ready is the transfer)
rx_data  out  8  byte shifted in from MISO
rx_valid  out  1  one-cycle pulse; rx_data is valid
busy  out  1  high from accepted start until GAP has elapsed
done  out  1  one-cycle pulse when CS_N deasserts at the end of a frame
CS_N  out  1  slave select, active low
SCK  out  1  serial clock, idles low
MOSI  out  1  serial data out
MISO  in  1  serial data in

Behaviour:
- Reset (async assert, synchronous release) forces these values immediately, even mid-frame; a partial frame is abandoned with no done pulse:
  - CS_N=1, SCK=0, MOSI=0
  - tx_ready=0, rx_valid=0, done=0, busy=0, rx_data=0x00
  - state=IDLE
- States: IDLE, SETUP, LOAD, LOW, HIGH, NEXT, GAP.
- IDLE:
  - start=1 and len!=0: latch len into remaining counter, set busy=1, CS_N=0, go to SETUP.
  - start with len=0: ignored; busy stays 0.
  - start in any other state: ignored.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD:
  - tx_ready=1 while tx_valid=0; SCK stays low and CS_N stays asserted indefinitely (stall).
  - On tx_valid && tx_ready: shift register <= tx_data, bit counter <= 7, MOSI <= tx_data[7], go to LOW.
- LOW: SCK=0 for CLK_DIV cycles with MOSI stable. On the last cycle, drive SCK=1 next cycle and sample MISO into rx shift register LSB (MSB-first accumulation). Go to HIGH.
- HIGH: SCK=1 for CLK_DIV cycles, then SCK=0.
  - bit counter != 0: decrement it, MOSI <= next bit on the same cycle SCK falls, go to LOW.
  - bit counter == 0: go to NEXT.
- NEXT:
  - rx_data <= assembled byte, rx_valid pulses for 1 cycle, remaining decrements.
  - remaining becomes 0: CS_N <= 1, done pulses, go to GAP.
  - Otherwise: go to LOAD, with SCK low throughout.
- GAP: CS_N=1 for CS_GAP cycles, then busy=0, go to IDLE. The earliest next start is accepted the cycle after busy falls.
- Timing:
  - One bit = 2*CLK_DIV clk cycles.
  - Unstalled byte = 16*CLK_DIV cycles plus 1 LOAD and 1 NEXT cycle.
  - MOSI changes only while SCK is low, or on the SCK falling cycle; never on a rising edge.
- Read-back convention: software sends the command byte, then a 0x00 dummy byte. It uses the rx byte of the dummy, per the slave's falling-edge preload timing.
- Counters:
  - Half-period counter is 8 bits and wraps only via explicit reload.
  - remaining is 3 bits; len>6 is clipped to 6.
- tx_ready is 0 outside LOAD. A tx_valid arriving outside LOAD is held by the source and consumed in LOAD.
- Simultaneous start and reset: reset wins.

Test Plan:
- Loopback, CLK_DIV=4: MISO tied to MOSI; len=2, bytes 0x1A,0x05 -> rx 0x1A then 0x05; 16 SCK rising edges; CS_N low continuously; done once; MOSI stream 00011010 00000101.
- Cookie read: slave model returns 0xAF on the byte after command 0x00; len=2, bytes 0x00,0x00 -> second rx_valid carries 0xAF; busy falls CS_GAP cycles after done.
- Stall: tx_valid withheld 50 cycles before byte 2 -> SCK low, CS_N low, tx_ready high for 50 cycles; frame resumes with correct bits.
- Timing: CLK_DIV=2, CS_SETUP=2 -> first SCK rise 2+1+2 cycles after CS_N fall; SCK high/low widths exactly 2 cycles; MOSI never toggles on a rise.
- Start filtering: start with len=0 -> no CS_N activity. start asserted while busy -> ignored, one done only.
- Reset mid-byte (after 3 bits): CS_N=1, SCK=0, MOSI=0 in the same cycle, no done. Next start runs a clean full frame.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command initiator.
// Frames 1..6 bytes under a single CS_N assertion, shifts MSB-first on MOSI,
// samples MISO on SCK rising edges and returns one received byte per sent byte.
// SCK idles low; MOSI only moves while SCK is low or on the SCK falling cycle.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV  = 4,  // clk cycles per SCK half-period (2..255)
  parameter int unsigned CS_SETUP = 2,  // clk cycles from CS_N fall to first LOAD
  parameter int unsigned CS_GAP   = 4   // clk cycles CS_N stays high after a frame
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       CS_N,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO
);

  // Reload values for the shared 8-bit down-counter (expires at zero).
  localparam logic [7:0] DIV_RELOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_RELOAD = 8'(CS_SETUP - 1);
  localparam logic [7:0] GAP_RELOAD   = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_NEXT  = 3'd5,
    S_GAP   = 3'd6
  } state_e;

  // Frame length is at most six bytes; larger requests are clipped.
  function automatic logic [2:0] clip_len(input logic [2:0] l);
    logic [2:0] r;
    if (l > 3'd6) begin
      r = 3'd6;
    end else begin
      r = l;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;        // setup / half-period / gap counter
  logic [2:0]  bit_q, bit_d;        // bits still to shift after the current one
  logic [2:0]  rem_q, rem_d;        // bytes remaining in the frame
  logic [6:0]  sh_tx_q, sh_tx_d;    // bits of the current byte not yet on MOSI
  logic [7:0]  sh_rx_q, sh_rx_d;    // MISO accumulation, MSB first
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic        xfer_s;              // byte handshake this cycle
  logic        cnt_zero_s;

  assign xfer_s     = tx_valid && tx_ready_q;
  assign cnt_zero_s = (cnt_q == 8'd0);

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 3'd0;
      rem_q      <= 3'd0;
      sh_tx_q    <= 7'd0;
      sh_rx_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rem_q      <= rem_d;
      sh_tx_q    <= sh_tx_d;
      sh_rx_q    <= sh_rx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
    end
  end

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && (len != 3'd0)) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_zero_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_LOAD: begin
        if (xfer_s) begin
          state_d = S_LOW;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOW: begin
        if (cnt_zero_s) begin
          state_d = S_HIGH;
        end else begin
          state_d = S_LOW;
        end
      end
      S_HIGH: begin
        if (cnt_zero_s && (bit_q == 3'd0)) begin
          state_d = S_NEXT;
        end else if (cnt_zero_s) begin
          state_d = S_LOW;
        end else begin
          state_d = S_HIGH;
        end
      end
      S_NEXT: begin
        if (rem_q == 3'd1) begin
          state_d = S_GAP;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_GAP: begin
        if (cnt_zero_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values for counters, shifters and the registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    rem_d      = rem_q;
    sh_tx_d    = sh_tx_q;
    sh_rx_d    = sh_rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    tx_ready_d = (state_d == S_LOAD);
    case (state_q)
      S_IDLE: begin
        if (start && (len != 3'd0)) begin
          rem_d  = clip_len(len);
          busy_d = 1'b1;
          cs_n_d = 1'b0;
          cnt_d  = SETUP_RELOAD;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_zero_s) begin
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOAD: begin
        // MSB goes straight to MOSI; the rest waits in the shifter.
        if (xfer_s) begin
          sh_tx_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          bit_d   = 3'd7;
          cnt_d   = DIV_RELOAD;
        end else begin
          sck_d = 1'b0;
        end
      end
      S_LOW: begin
        // SCK rises next cycle; capture MISO while it is still settled.
        if (cnt_zero_s) begin
          sck_d   = 1'b1;
          sh_rx_d = {sh_rx_q[6:0], MISO};
          cnt_d   = DIV_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        // The next MOSI bit is launched on the same cycle SCK falls.
        if (cnt_zero_s && (bit_q != 3'd0)) begin
          sck_d   = 1'b0;
          bit_d   = bit_q - 3'd1;
          mosi_d  = sh_tx_q[6];
          sh_tx_d = {sh_tx_q[5:0], 1'b0};
          cnt_d   = DIV_RELOAD;
        end else if (cnt_zero_s) begin
          sck_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_NEXT: begin
        rx_data_d  = sh_rx_q;
        rx_valid_d = 1'b1;
        rem_d      = rem_q - 3'd1;
        if (rem_q == 3'd1) begin
          cs_n_d = 1'b1;
          done_d = 1'b1;
          mosi_d = 1'b0;
          cnt_d  = GAP_RELOAD;
        end else begin
          cs_n_d = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt_zero_s) begin
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign CS_N     = cs_n_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: loopback, cookie read, stall,
// timing, start filtering and mid-frame reset.
module tb_spi_cmd_master;

  localparam int DIV   = 2;
  localparam int SETUP = 2;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] len = 3'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       CS_N;
  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       loop_en = 1'b1;
  logic       slv_out = 1'b0;

  assign MISO = loop_en ? MOSI : slv_out;

  spi_cmd_master #(.CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .CS_N(CS_N), .SCK(SCK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] tx_bytes [6];

  // observation state (negedge monitor)
  int          rises_total = 0, rif = 0, rise_tog = 0, hi_bad = 0, lo_bad = 0;
  int          hi_run = 0, lo_run = 0, cs_fall_total = 0, cs_rise_total = 0;
  int          done_total = 0, lat_cnt = 0, last_lat = -1, gap_cnt = 0, last_gap = -1;
  bit          lat_pend = 0, gap_pend = 0;
  logic        sck_p = 1'b0, cs_p = 1'b1, mosi_p = 1'b0;
  logic [63:0] mosi_hist = 64'd0;

  // slave model state
  int          s_fall = 0;
  logic        s_sck_p = 1'b0;
  logic [7:0]  slv_cmd = 8'hFF;
  logic [7:0]  cookie_v = 8'hAF;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_mon();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", int'(rx_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", int'(rx_data), int'(e));
        end
      end
    end
  endtask

  task automatic tim_mon();
    forever begin
      @(negedge clk);
      if (cs_p && !CS_N) begin
        cs_fall_total++; lat_cnt = 0; lat_pend = 1; rif = 0;
      end else if (lat_pend) begin
        lat_cnt++;
      end
      if (!cs_p && CS_N) cs_rise_total++;
      if (!sck_p && SCK) begin
        rises_total++;
        mosi_hist = {mosi_hist[62:0], MOSI};
        if (MOSI != mosi_p) rise_tog++;
        if ((rif % 8) != 0 && lo_run != DIV) lo_bad++;
        rif++;
        if (lat_pend) begin last_lat = lat_cnt; lat_pend = 0; end
      end
      if (sck_p && !SCK && hi_run != DIV) hi_bad++;
      if (SCK) hi_run = sck_p ? hi_run + 1 : 1;
      else     lo_run = sck_p ? 1 : lo_run + 1;
      if (done) begin
        done_total++; gap_cnt = 0; gap_pend = 1;
      end else if (gap_pend) begin
        gap_cnt++;
        if (!busy) begin last_gap = gap_cnt; gap_pend = 0; end
      end
      sck_p = SCK; cs_p = CS_N; mosi_p = MOSI;
    end
  endtask

  // Command-slave model: captures the command on rises, answers 0xAF in the
  // byte following command 0x00, changing MISO after SCK falls.
  task automatic slv_model();
    logic [2:0] bi;
    forever begin
      @(negedge clk);
      if (CS_N) begin
        s_fall = 0; slv_out = 1'b0; slv_cmd = 8'hFF;
      end else begin
        if (SCK && !s_sck_p && s_fall < 8) slv_cmd = {slv_cmd[6:0], MOSI};
        if (!SCK && s_sck_p) begin
          s_fall++;
          bi = 3'(7 - (s_fall % 8));
          if (s_fall >= 8 && s_fall < 16 && slv_cmd == 8'h00) slv_out = cookie_v[bi];
          else slv_out = 1'b0;
        end
      end
      s_sck_p = SCK;
    end
  endtask

  task automatic send_frame(input int n, input int stall_idx, input int stall_len);
    int bound;
    int bad;
    @(negedge clk); start = 1'b1; len = 3'(n);
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == stall_idx) begin
        bound = 0;
        while (!tx_ready && bound < 1000) begin @(negedge clk); bound++; end
        chk("stall_reach_load", int'(tx_ready), 1);
        bad = 0;
        for (int c = 0; c < stall_len; c++) begin
          if (SCK != 1'b0 || CS_N != 1'b0 || tx_ready != 1'b1) bad++;
          @(negedge clk);
        end
        chk("stall_hold", bad, 0);
      end
      tx_data = tx_bytes[k]; tx_valid = 1'b1;
      bound = 0;
      while (!tx_ready && bound < 1000) begin @(negedge clk); bound++; end
      chk("tx_ready_wait", int'(bound < 1000), 1);
      @(posedge clk); #1; tx_valid = 1'b0;
    end
    bound = 0;
    while (busy && bound < 3000) begin @(negedge clk); bound++; end
    chk("frame_end_wait", int'(bound < 3000), 1);
  endtask

  int r0, d0, cf0, cr0, hb0, lb0, bound, busy_cnt;

  initial begin
    fork
      sb_mon();
      tim_mon();
      slv_model();
    join_none

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(CS_N), 1);
    chk("rst_sck", int'(SCK), 0);
    chk("rst_mosi", int'(MOSI), 0);
    chk("rst_tx_ready", int'(tx_ready), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // loopback 0x1A, 0x05
    tx_bytes[0] = 8'h1A; tx_bytes[1] = 8'h05;
    exp_q.push_back(8'h1A); exp_q.push_back(8'h05);
    r0 = rises_total; d0 = done_total; cr0 = cs_rise_total; hb0 = hi_bad; lb0 = lo_bad;
    send_frame(2, -1, 0);
    chk("lb_sck_rises", rises_total - r0, 16);
    chk("lb_done_count", done_total - d0, 1);
    chk("lb_cs_rises", cs_rise_total - cr0, 1);
    chk("lb_mosi_stream", int'(mosi_hist[15:0]), 32'h1A05);
    chk("first_rise_latency", last_lat, SETUP + 1 + DIV);
    chk("sck_high_width", hi_bad - hb0, 0);
    chk("sck_low_width", lo_bad - lb0, 0);
    chk("lb_gap", last_gap, GAP);

    // cookie read
    loop_en = 1'b0;
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;
    exp_q.push_back(8'h00); exp_q.push_back(8'hAF);
    d0 = done_total;
    send_frame(2, -1, 0);
    chk("cookie_done_count", done_total - d0, 1);
    chk("cookie_busy_gap", last_gap, GAP);
    loop_en = 1'b1;

    // stall 50 cycles before byte 2
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'h96;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'h96);
    r0 = rises_total; d0 = done_total;
    send_frame(3, 1, 50);
    chk("stall_sck_rises", rises_total - r0, 24);
    chk("stall_done_count", done_total - d0, 1);
    chk("stall_mosi_stream", int'(mosi_hist[23:0]), 32'hA53C96);

    // start with len=0 is ignored
    cf0 = cs_fall_total; busy_cnt = 0;
    @(negedge clk); start = 1'b1; len = 3'd0;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("len0_cs_falls", cs_fall_total - cf0, 0);
    chk("len0_busy_cycles", busy_cnt, 0);

    // reset after 3 bits of byte 0xFF
    r0 = rises_total; d0 = done_total;
    @(negedge clk); start = 1'b1; len = 3'd2;
    @(negedge clk); start = 1'b0;
    tx_data = 8'hFF; tx_valid = 1'b1;
    bound = 0;
    while (!tx_ready && bound < 1000) begin @(negedge clk); bound++; end
    @(posedge clk); #1; tx_valid = 1'b0;
    bound = 0;
    while (rises_total < r0 + 3 && bound < 1000) begin @(negedge clk); bound++; end
    chk("rst_mid_reach_bit3", rises_total - r0, 3);
    chk("rst_mid_mosi_before", int'(MOSI), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", int'(CS_N), 1);
    chk("rst_mid_sck", int'(SCK), 0);
    chk("rst_mid_mosi", int'(MOSI), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", done_total - d0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean frame after reset, with a start pulse while busy
    tx_bytes[0] = 8'h3C; tx_bytes[1] = 8'hC3;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    r0 = rises_total; d0 = done_total; cf0 = cs_fall_total;
    fork
      send_frame(2, -1, 0);
      begin
        repeat (30) @(negedge clk);
        start = 1'b1; len = 3'd3;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("busy_start_sck_rises", rises_total - r0, 16);
    chk("busy_start_done_count", done_total - d0, 1);
    chk("busy_start_cs_falls", cs_fall_total - cf0, 1);
    chk("post_rst_mosi_stream", int'(mosi_hist[15:0]), 32'h3CC3);

    chk("mosi_toggle_on_rise", rise_tog, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
